mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-master arbiter for the single shared DLX memory port. Master 0 is the control state machine's fetch/load/store interface; master 1 is the debug/monitor loader. The block grants the memory port to one requester at a time and muxes address, data and read/write strobes onto the memory interface. It returns a per-master `BUSY` with the same semantics the control FSM already uses: hold `REQ` while `BUSY`=1, and the transfer completes in the cycle `BUSY`=0. A wait-state watchdog aborts transfers that the memory never acknowledges.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width
- `TIMEOUT`, 15, grant cycles without `MEM_ACK` before abort (1..255)

Ports:
- `CLK` in 1: single clock; all state updates on rising edge
- `RESET` in 1: synchronous, active-high
- `M0_REQ`, `M1_REQ` in 1: transfer request, held until `BUSY`=0
- `M0_MR`, `M1_MR` in 1: read strobe
- `M0_MW`, `M1_MW` in 1: write strobe
- `M0_ADDR`, `M1_ADDR` in AW: address
- `M0_DIN`, `M1_DIN` in DW: write data
- `M0_BUSY`, `M1_BUSY` out 1: transfer pending
- `M0_ERR`, `M1_ERR` out 1: one-cycle abort pulse, coincident with `BUSY`=0
- `M_DOUT` out DW: read data; `MEM_DOUT` passed through combinationally
- `MEM_REQ`, `MEM_MR`, `MEM_MW` out 1: memory strobes
- `MEM_ADDR` out AW, `MEM_DIN` out DW: memory address/data
- `MEM_ACK` in 1: memory completes the transfer this cycle
- `MEM_DOUT` in DW: memory read data, valid with `MEM_ACK`
- `GRANT_o` out 2: one-hot current grant ({M1,M0}); 00 when idle
- `STATE_o` out 2: FSM state, for debug

## Operation
States: `IDLE`=0, `G0`=1, `G1`=2 (3 unused, decodes to `IDLE`).
- `IDLE`: `MEM_REQ`=0. If any `REQ` is high, the winner is registered and the FSM moves to `G0`/`G1`. Otherwise the FSM stays in `IDLE`.
- `Gx`: `MEM_REQ`=1. `MEM_MR`/`MEM_MW`/`MEM_ADDR`/`MEM_DIN` are driven combinationally from master x. The other master's signals are ignored.
  - `MEM_ACK`=1: `Mx_BUSY`=0 in this cycle; next state `IDLE`.
  - `Mx_REQ` drops while granted (abandon): `MEM_REQ`=0 in this cycle, no `ERR`; next state `IDLE`.
  - `Mx_MR`=`Mx_MW`=0 (illegal): `MEM_REQ` is suppressed; `Mx_ERR`=1 and `Mx_BUSY`=0 in the first grant cycle; next state `IDLE`.
  - Wait counter reaches `TIMEOUT` without ack: `Mx_ERR`=1, `Mx_BUSY`=0, `MEM_REQ`=0 in that cycle; next state `IDLE`.
  - `MR`=`MW`=1: passed through unchanged; the memory decides.
- `Mx_BUSY` = `Mx_REQ` & ~(granted to x & (`MEM_ACK` | abort | illegal)). A non-requesting master always reads `BUSY`=0.
- Wait counter: 8 bits. Cleared on entry to `Gx`, increments each `Gx` cycle without `MEM_ACK`. Abort fires when the counter equals `TIMEOUT`-1 in a non-ack cycle, i.e. on the `TIMEOUT`-th grant cycle.
- `MEM_ACK` while in `IDLE` is ignored.
- Non-granted master outputs: `M_DOUT` is valid only for the granted master in its completion cycle. Both masters see the same bus, and a non-granted master must ignore it.

## Timing
- Reset values: state `IDLE`, `GRANT_o`=00, counter 0, last-served=M1. Outputs: `MEM_REQ`/`MEM_MR`/`MEM_MW`=0, `ERR`=0, `BUSY`=`REQ` (combinational), `MEM_ADDR`/`MEM_DIN`=0.
- Minimum latency: `REQ` rises in cycle n (`IDLE`) → grant in n+1 → with same-cycle `MEM_ACK`, `BUSY`=0 in n+1. One transfer takes at least 2 cycles; back-to-back transfers require a return to `IDLE`, so there is 1 bubble between grants.
- `RESET` mid-transfer: the FSM returns to `IDLE` on the next edge. `MEM_REQ` drops in that cycle; no `ERR` pulse; the counter clears.
- Simultaneous requests in `IDLE` are resolved per Configuration.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: a last-served register (reset M1) updates on every completion or abort. On a tie the master not served last wins, so alternating contention yields M0, M1, M0, ...
- Not defined: fixed priority, M0 always wins ties. The last-served register is not implemented, and M1 can starve.
- A single requester is served identically in both builds.

## Test plan
- Single read: `M0_REQ`/`MR`=1, `ADDR`=0x40; memory acks 2 cycles after `MEM_REQ` with `MEM_DOUT`=0xDEADBEEF → `M0_BUSY` high for 3 cycles then low for one cycle with `M_DOUT`=0xDEADBEEF; `GRANT_o`=01 then 00.
- Contention: both masters request writes in the same `IDLE` cycle, ack immediately each grant → fixed build: M0, M1; `ARB_ROUND_ROBIN_EN` build after a prior M0 transfer: M1 first. `MEM_ADDR` switches accordingly; 1 idle cycle between grants.
- Timeout: `TIMEOUT`=4, M1 write, `MEM_ACK` never asserted → `M1_ERR`=1 and `M1_BUSY`=0 on the 4th grant cycle; `MEM_REQ`=0 that cycle; FSM back in `IDLE`.
- Illegal request: `M0_REQ`=1, `MR`=`MW`=0 → `MEM_REQ` stays 0; `M0_ERR` pulse in the first grant cycle.
- Reset mid-grant: `RESET` pulsed in the 2nd wait cycle of an M0 read → `STATE_o`=0, `GRANT_o`=00, `MEM_REQ`=0 after the edge, no `ERR`. With `REQ` still held, a fresh grant is issued the cycle after `RESET` falls.
- Abandon: M0 granted, `M0_REQ` dropped before ack → `MEM_REQ`=0 the same cycle, no `ERR`; a pending M1 request is granted next.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the shared DLX memory port, with a wait-state watchdog.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; the default build uses fixed M0 priority.
module mem_bus_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          M0_REQ,
    input  logic          M1_REQ,
    input  logic          M0_MR,
    input  logic          M1_MR,
    input  logic          M0_MW,
    input  logic          M1_MW,
    input  logic [AW-1:0] M0_ADDR,
    input  logic [AW-1:0] M1_ADDR,
    input  logic [DW-1:0] M0_DIN,
    input  logic [DW-1:0] M1_DIN,
    output logic          M0_BUSY,
    output logic          M1_BUSY,
    output logic          M0_ERR,
    output logic          M1_ERR,
    output logic [DW-1:0] M_DOUT,
    output logic          MEM_REQ,
    output logic          MEM_MR,
    output logic          MEM_MW,
    output logic [AW-1:0] MEM_ADDR,
    output logic [DW-1:0] MEM_DIN,
    input  logic          MEM_ACK,
    input  logic [DW-1:0] MEM_DOUT,
    output logic [1:0]    GRANT_o,
    output logic [1:0]    STATE_o
);

    localparam int unsigned CW = 8;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_G0   = 2'd1;
    localparam logic [1:0] ST_G1   = 2'd2;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] wait_cnt;
    logic          g0;
    logic          g1;
    logic          granted;
    logic          sel_req;
    logic          sel_mr;
    logic          sel_mw;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_din;
    logic          illegal;
    logic          abort;
    logic          finish;
    logic          pick_m1;

    assign g0       = (state == ST_G0);
    assign g1       = (state == ST_G1);
    assign granted  = g0 | g1;
    assign sel_req  = g1 ? M1_REQ  : M0_REQ;
    assign sel_mr   = g1 ? M1_MR   : M0_MR;
    assign sel_mw   = g1 ? M1_MW   : M0_MW;
    assign sel_addr = g1 ? M1_ADDR : M0_ADDR;
    assign sel_din  = g1 ? M1_DIN  : M0_DIN;

    // Transfer end conditions; an abandoned request (REQ low) is neither a finish nor an error.
    assign illegal = granted & sel_req & ~sel_mr & ~sel_mw;
    assign abort   = granted & sel_req & ~illegal & ~MEM_ACK & (wait_cnt == CNT_LAST);
    assign finish  = granted & sel_req & (MEM_ACK | illegal | abort);

    assign M_DOUT = MEM_DOUT;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_m1;

    // Remembers which master was served last, so ties go to the other one.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            last_m1 <= 1'b1;
        end else if (finish) begin
            last_m1 <= g1;
        end
    end

    assign pick_m1 = ~last_m1;
`else
    assign pick_m1 = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Wait-state counter: zero outside a grant, counts grant cycles that did not end the transfer.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wait_cnt <= '0;
        end else if (granted && (state_nxt == state)) begin
            wait_cnt <= wait_cnt + CW'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_G0, ST_G1: begin
                if (!sel_req || finish) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                if (M0_REQ && M1_REQ) begin
                    state_nxt = pick_m1 ? ST_G1 : ST_G0;
                end else if (M0_REQ) begin
                    state_nxt = ST_G0;
                end else if (M1_REQ) begin
                    state_nxt = ST_G1;
                end
            end
        endcase
    end

    always_comb begin
        MEM_REQ  = 1'b0;
        MEM_MR   = 1'b0;
        MEM_MW   = 1'b0;
        MEM_ADDR = '0;
        MEM_DIN  = '0;
        if (granted) begin
            MEM_REQ  = sel_req & ~illegal & ~abort;
            MEM_MR   = sel_mr;
            MEM_MW   = sel_mw;
            MEM_ADDR = sel_addr;
            MEM_DIN  = sel_din;
        end
        M0_BUSY = M0_REQ & ~(g0 & finish);
        M1_BUSY = M1_REQ & ~(g1 & finish);
        M0_ERR  = g0 & (illegal | abort);
        M1_ERR  = g1 & (illegal | abort);
        GRANT_o = {g1, g0};
        STATE_o = state;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (TIMEOUT=4): read, contention, timeout, illegal, reset, abandon.
module tb_mem_bus_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit FIRST_M1 = 1'b1;
`else
    localparam bit FIRST_M1 = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RESET;
    logic          M0_REQ, M1_REQ, M0_MR, M1_MR, M0_MW, M1_MW;
    logic [AW-1:0] M0_ADDR, M1_ADDR;
    logic [DW-1:0] M0_DIN, M1_DIN;
    logic          M0_BUSY, M1_BUSY, M0_ERR, M1_ERR;
    logic [DW-1:0] M_DOUT;
    logic          MEM_REQ, MEM_MR, MEM_MW;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_DIN;
    logic          MEM_ACK;
    logic [DW-1:0] MEM_DOUT;
    logic [1:0]    GRANT_o, STATE_o;

    int n_assert = 0;
    int n_fail   = 0;

    mem_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .M0_REQ(M0_REQ), .M1_REQ(M1_REQ),
        .M0_MR(M0_MR), .M1_MR(M1_MR),
        .M0_MW(M0_MW), .M1_MW(M1_MW),
        .M0_ADDR(M0_ADDR), .M1_ADDR(M1_ADDR),
        .M0_DIN(M0_DIN), .M1_DIN(M1_DIN),
        .M0_BUSY(M0_BUSY), .M1_BUSY(M1_BUSY),
        .M0_ERR(M0_ERR), .M1_ERR(M1_ERR),
        .M_DOUT(M_DOUT),
        .MEM_REQ(MEM_REQ), .MEM_MR(MEM_MR), .MEM_MW(MEM_MW),
        .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN),
        .MEM_ACK(MEM_ACK), .MEM_DOUT(MEM_DOUT),
        .GRANT_o(GRANT_o), .STATE_o(STATE_o)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        @(negedge CLK);
    endtask

    initial begin
        RESET = 1'b1;
        M0_REQ = 0; M1_REQ = 0; M0_MR = 0; M1_MR = 0; M0_MW = 0; M1_MW = 0;
        M0_ADDR = '0; M1_ADDR = '0; M0_DIN = '0; M1_DIN = '0;
        MEM_ACK = 0; MEM_DOUT = '0;
        cyc(); cyc();

        // Reset state; BUSY follows REQ even under reset
        M1_REQ = 1; M1_MW = 1;
        mid();
        chk("rst_state",  32'(STATE_o), 0);
        chk("rst_grant",  32'(GRANT_o), 0);
        chk("rst_memreq", 32'(MEM_REQ), 0);
        chk("rst_addr",   MEM_ADDR, 0);
        chk("rst_busy1",  32'(M1_BUSY), 1);
        chk("rst_err1",   32'(M1_ERR), 0);
        cyc();
        M1_REQ = 0; M1_MW = 0;
        cyc();
        RESET = 1'b0;

        // Single M0 read, ack two cycles after MEM_REQ rises
        M0_REQ = 1; M0_MR = 1; M0_ADDR = 32'h40;
        mid();
        chk("rd_idle_busy", 32'(M0_BUSY), 1);
        chk("rd_idle_req",  32'(MEM_REQ), 0);
        cyc();
        mid();
        chk("rd_grant",   32'(GRANT_o), 1);
        chk("rd_state",   32'(STATE_o), 1);
        chk("rd_memreq",  32'(MEM_REQ), 1);
        chk("rd_memmr",   32'(MEM_MR), 1);
        chk("rd_addr",    MEM_ADDR, 32'h40);
        chk("rd_busy_g1", 32'(M0_BUSY), 1);
        cyc();
        mid();
        chk("rd_busy_g2", 32'(M0_BUSY), 1);
        cyc();
        MEM_ACK = 1; MEM_DOUT = 32'hDEADBEEF;
        mid();
        chk("rd_busy_ack", 32'(M0_BUSY), 0);
        chk("rd_dout",     M_DOUT, 32'hDEADBEEF);
        chk("rd_err",      32'(M0_ERR), 0);
        cyc();
        M0_REQ = 0; M0_MR = 0; MEM_ACK = 0; MEM_DOUT = '0;
        mid();
        chk("rd_done_grant", 32'(GRANT_o), 0);
        chk("rd_done_state", 32'(STATE_o), 0);
        cyc();

        // Contention: both masters write in the same IDLE cycle
        M0_REQ = 1; M0_MW = 1; M0_ADDR = 32'h100; M0_DIN = 32'h11;
        M1_REQ = 1; M1_MW = 1; M1_ADDR = 32'h200; M1_DIN = 32'h22;
        mid();
        chk("ct_idle_b0", 32'(M0_BUSY), 1);
        chk("ct_idle_b1", 32'(M1_BUSY), 1);
        cyc();
        MEM_ACK = 1;
        mid();
        chk("ct1_grant", 32'(GRANT_o), FIRST_M1 ? 2 : 1);
        chk("ct1_addr",  MEM_ADDR, FIRST_M1 ? 32'h200 : 32'h100);
        chk("ct1_din",   MEM_DIN,  FIRST_M1 ? 32'h22 : 32'h11);
        chk("ct1_mw",    32'(MEM_MW), 1);
        chk("ct1_b0",    32'(M0_BUSY), FIRST_M1 ? 1 : 0);
        chk("ct1_b1",    32'(M1_BUSY), FIRST_M1 ? 0 : 1);
        cyc();
        // Bubble cycle; an ack in IDLE must not complete the waiting master
        if (FIRST_M1) begin M1_REQ = 0; M1_MW = 0; end
        else          begin M0_REQ = 0; M0_MW = 0; end
        mid();
        chk("ct_bub_state", 32'(STATE_o), 0);
        chk("ct_bub_req",   32'(MEM_REQ), 0);
        chk("ct_bub_busy",  32'(FIRST_M1 ? M0_BUSY : M1_BUSY), 1);
        cyc();
        mid();
        chk("ct2_grant", 32'(GRANT_o), FIRST_M1 ? 1 : 2);
        chk("ct2_addr",  MEM_ADDR, FIRST_M1 ? 32'h100 : 32'h200);
        chk("ct2_busy",  32'(FIRST_M1 ? M0_BUSY : M1_BUSY), 0);
        cyc();
        M0_REQ = 0; M0_MW = 0; M1_REQ = 0; M1_MW = 0; MEM_ACK = 0;
        mid();
        chk("ct_end_state", 32'(STATE_o), 0);

        // Timeout: M1 write never acked, abort on the 4th grant cycle
        M1_REQ = 1; M1_MW = 1; M1_ADDR = 32'h300;
        cyc();
        mid();
        chk("to_g1_req",  32'(MEM_REQ), 1);
        chk("to_g1_err",  32'(M1_ERR), 0);
        cyc();
        cyc();
        mid();
        chk("to_g3_busy", 32'(M1_BUSY), 1);
        chk("to_g3_err",  32'(M1_ERR), 0);
        cyc();
        mid();
        chk("to_g4_err",   32'(M1_ERR), 1);
        chk("to_g4_busy",  32'(M1_BUSY), 0);
        chk("to_g4_req",   32'(MEM_REQ), 0);
        chk("to_g4_grant", 32'(GRANT_o), 2);
        cyc();
        mid();
        chk("to_idle_state", 32'(STATE_o), 0);
        chk("to_idle_err",   32'(M1_ERR), 0);
        M1_REQ = 0; M1_MW = 0;
        cyc();

        // Illegal request: neither strobe set
        M0_REQ = 1; M0_ADDR = 32'h44;
        cyc();
        mid();
        chk("il_state", 32'(STATE_o), 1);
        chk("il_req",   32'(MEM_REQ), 0);
        chk("il_err",   32'(M0_ERR), 1);
        chk("il_busy",  32'(M0_BUSY), 0);
        cyc();
        mid();
        chk("il_idle", 32'(STATE_o), 0);
        chk("il_err2", 32'(M0_ERR), 0);
        M0_REQ = 0;
        cyc();

        // Reset in the 2nd wait cycle of an M0 read
        M0_REQ = 1; M0_MR = 1; M0_ADDR = 32'h80;
        cyc();
        cyc();
        RESET = 1;
        cyc();
        RESET = 0;
        mid();
        chk("rm_state", 32'(STATE_o), 0);
        chk("rm_grant", 32'(GRANT_o), 0);
        chk("rm_req",   32'(MEM_REQ), 0);
        chk("rm_err",   32'(M0_ERR), 0);
        chk("rm_busy",  32'(M0_BUSY), 1);
        cyc();
        M1_REQ = 1; M1_MR = 1; M1_ADDR = 32'h500;
        mid();
        chk("rm_regrant", 32'(GRANT_o), 1);
        chk("rm_memreq",  32'(MEM_REQ), 1);
        cyc();

        // Abandon: M0 drops REQ before ack, pending M1 is served next
        M0_REQ = 0; M0_MR = 0;
        mid();
        chk("ab_req",   32'(MEM_REQ), 0);
        chk("ab_err",   32'(M0_ERR), 0);
        chk("ab_busy0", 32'(M0_BUSY), 0);
        chk("ab_busy1", 32'(M1_BUSY), 1);
        cyc();
        mid();
        chk("ab_idle", 32'(STATE_o), 0);
        cyc();
        MEM_ACK = 1; MEM_DOUT = 32'h12345678;
        mid();
        chk("ab_g1_grant", 32'(GRANT_o), 2);
        chk("ab_g1_addr",  MEM_ADDR, 32'h500);
        chk("ab_g1_mr",    32'(MEM_MR), 1);
        chk("ab_g1_busy",  32'(M1_BUSY), 0);
        chk("ab_g1_dout",  M_DOUT, 32'h12345678);
        cyc();
        M1_REQ = 0; M1_MR = 0; MEM_ACK = 0;
        mid();
        chk("ab_end_state", 32'(STATE_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
